// File: rtl/adc_spi_sampler.sv
// adc_spi_sampler: periodic SPI reader for a 12-bit, 8-channel serial ADC (ADC128S102-style frame).
// Optional build macro SAMPLE_AVG4_EN: strobe once per four frames with the truncated mean.
module adc_spi_sampler #(
  parameter int         CLK_DIV       = 4,
  parameter int         SAMPLE_PERIOD = 50000,
  parameter logic [2:0] CHANNEL       = 3'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        adc_sdo,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_din,
  output logic [11:0] origin_data,
  output logic        en_kalman,
  output logic        busy,
  output logic        overrun
);

  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [DW-1:0] DIV_LAST    = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] period_cnt;
  logic [DW-1:0] div_q, div_d;
  logic [4:0]    half_q, half_d;
  logic          cs_n_d, sclk_d, din_d, busy_d;
  logic          tick, div_last, sample_en, frame_end, strobe;
  logic [11:0]   shreg_p0, result;

  // Frame bits 2..4 carry the channel address MSB first; everything else is zero.
  function automatic logic din_bit(input logic [3:0] n);
    case (n)
      4'd2:    return CHANNEL[2];
      4'd3:    return CHANNEL[1];
      4'd4:    return CHANNEL[0];
      default: return 1'b0;
    endcase
  endfunction

  assign tick     = en && (period_cnt == PERIOD_LAST);
  assign div_last = (div_q == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || !en || tick) period_cnt <= '0;
    else                       period_cnt <= period_cnt + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    half_d    = half_q;
    cs_n_d    = 1'b1;
    sclk_d    = 1'b1;
    din_d     = 1'b0;
    busy_d    = 1'b0;
    sample_en = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SETUP;
          div_d   = '0;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      SETUP: begin
        cs_n_d = 1'b0;
        busy_d = 1'b1;
        if (div_last) begin
          state_d = SHIFT;
          div_d   = '0;
          half_d  = '0;
          sclk_d  = 1'b0;
          din_d   = din_bit(4'd0);
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      SHIFT: begin
        cs_n_d    = 1'b0;
        busy_d    = 1'b1;
        sclk_d    = half_q[0];
        din_d     = adc_din;
        // Capture on the clk that raises SCLK, skipping the four leading zeros.
        sample_en = div_last && !half_q[0] && (half_q[4:1] >= 4'd4);
        if (div_last) begin
          div_d = '0;
          if (half_q == 5'd31) begin
            state_d   = DONE;
            cs_n_d    = 1'b1;
            sclk_d    = 1'b1;
            din_d     = 1'b0;
            frame_end = 1'b1;
          end else begin
            half_d = half_q + 1'b1;
            sclk_d = ~half_q[0];
            if (half_q[0]) din_d = din_bit(half_q[4:1] + 1'b1);
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Stage p0: serial-to-parallel capture of D11..D0
  always_ff @(posedge clk) begin
    if (sample_en) shreg_p0 <= {shreg_p0[10:0], adc_sdo};
  end

`ifdef SAMPLE_AVG4_EN
  logic [13:0] acc_p1, acc_sum;
  logic [1:0]  frame_cnt;

  function automatic logic [11:0] avg4_trunc(input logic [13:0] s);
    return s[13:2];
  endfunction

  assign acc_sum = acc_p1 + {2'b00, shreg_p0};
  assign strobe  = frame_end && en && (frame_cnt == 2'd3);
  assign result  = avg4_trunc(acc_sum);

  // Stage p1: four-frame accumulation, cleared whenever sampling is disabled
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      acc_p1    <= '0;
      frame_cnt <= '0;
    end else if (frame_end) begin
      frame_cnt <= frame_cnt + 1'b1;
      acc_p1    <= (frame_cnt == 2'd3) ? 14'd0 : acc_sum;
    end
  end
`else
  assign strobe = frame_end;
  assign result = shreg_p0;
`endif

  // Output stage: registered pins, result and strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      div_q       <= '0;
      half_q      <= '0;
      adc_cs_n    <= 1'b1;
      adc_sclk    <= 1'b1;
      adc_din     <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      en_kalman   <= 1'b0;
      origin_data <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      half_q    <= half_d;
      adc_cs_n  <= cs_n_d;
      adc_sclk  <= sclk_d;
      adc_din   <= din_d;
      busy      <= busy_d;
      overrun   <= overrun | (tick && (state_q != IDLE));
      en_kalman <= strobe;
      if (strobe) origin_data <= result;
    end
  end

endmodule

// File: tb/tb_adc_spi_sampler.sv
// tb_adc_spi_sampler: randomized bench for adc_spi_sampler with a behavioural serial ADC model.
// Build with SAMPLE_AVG4_EN defined to exercise the four-frame averaging variant.
module tb_adc_spi_sampler;

  localparam int         CD  = 2;
  localparam int         SP  = 100;
  localparam int         SP2 = 40;
  localparam int         FL  = 33 * CD;
  localparam logic [2:0] CH  = 3'd5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0, en = 1'b0, en2 = 1'b0;
  logic        adc_sdo = 1'b0, adc_sdo2 = 1'b0;
  logic        adc_cs_n, adc_sclk, adc_din, en_kalman, busy, overrun;
  logic        adc_cs_n2, adc_sclk2, adc_din2, en_kalman2, busy2, overrun2;
  logic [11:0] origin_data, origin_data2;

  adc_spi_sampler #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP), .CHANNEL(CH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .adc_sdo(adc_sdo), .adc_cs_n(adc_cs_n),
    .adc_sclk(adc_sclk), .adc_din(adc_din), .origin_data(origin_data),
    .en_kalman(en_kalman), .busy(busy), .overrun(overrun));

  adc_spi_sampler #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP2), .CHANNEL(3'd2)) dut_ovr (
    .clk(clk), .rst_n(rst_n), .en(en2), .adc_sdo(adc_sdo2), .adc_cs_n(adc_cs_n2),
    .adc_sclk(adc_sclk2), .adc_din(adc_din2), .origin_data(origin_data2),
    .en_kalman(en_kalman2), .busy(busy2), .overrun(overrun2));

  int n_cmp = 0, n_fail = 0, cyc = 0, last_s = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: frame {4'b0, value} shifted out MSB first on falling SCLK; DIN logged on rising SCLK.
  logic [11:0] adc_val = 12'h000, adc_val2 = 12'h000;
  logic [15:0] frame_w = '0, frame_w2 = '0, din_bits = '0;
  int          adc_bit = 0, adc_bit2 = 0, sclk_rises = 0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b1, prev_cs2 = 1'b1, prev_sclk2 = 1'b1;

  always @(adc_cs_n, adc_sclk) begin
    if (prev_cs === 1'b1 && adc_cs_n === 1'b0) begin
      frame_w = {4'b0000, adc_val}; adc_bit = 0; sclk_rises = 0; din_bits = '0;
    end else if (adc_cs_n === 1'b0 && prev_sclk === 1'b1 && adc_sclk === 1'b0 && adc_bit < 16) begin
      adc_sdo = frame_w[15 - adc_bit]; adc_bit++;
    end else if (adc_cs_n === 1'b0 && prev_sclk === 1'b0 && adc_sclk === 1'b1 && sclk_rises < 16) begin
      din_bits[15 - sclk_rises] = adc_din; sclk_rises++;
    end
    prev_cs = adc_cs_n; prev_sclk = adc_sclk;
  end

  always @(adc_cs_n2, adc_sclk2) begin
    if (prev_cs2 === 1'b1 && adc_cs_n2 === 1'b0) begin
      frame_w2 = {4'b0000, adc_val2}; adc_bit2 = 0;
    end else if (adc_cs_n2 === 1'b0 && prev_sclk2 === 1'b1 && adc_sclk2 === 1'b0 && adc_bit2 < 16) begin
      adc_sdo2 = frame_w2[15 - adc_bit2]; adc_bit2++;
    end
    prev_cs2 = adc_cs_n2; prev_sclk2 = adc_sclk2;
  end

  int   strobe_cnt = 0;
  logic prev_k = 1'b0, consec_seen = 1'b0;
  always @(negedge clk) begin
    if (en_kalman === 1'b1) begin
      strobe_cnt++;
      if (prev_k === 1'b1) consec_seen = 1'b1;
    end
    prev_k = en_kalman;
  end

  task automatic wait_cs_low(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (adc_cs_n === 1'b0) begin at = cyc; return; end
    end
  endtask

  task automatic wait_strobe(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (en_kalman === 1'b1) begin at = cyc; return; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; en2 = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({adc_cs_n, adc_sclk, adc_din, en_kalman, busy, overrun} !== 6'b110000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 110000", {adc_cs_n, adc_sclk, adc_din, en_kalman, busy, overrun});
    end
    n_cmp++;
    if (origin_data !== 12'h000) begin n_fail++; $display("FAIL reset_data: got %h want 000", origin_data); end
    n_cmp++;
    if ({adc_cs_n2, adc_sclk2, overrun2, origin_data2} !== {3'b110, 12'h000}) begin
      n_fail++; $display("FAIL reset_ovr_inst: got %b/%b/%b/%h", adc_cs_n2, adc_sclk2, overrun2, origin_data2);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    int n, c, s;
    adc_val = 12'hABC;
    n = cyc; en = 1'b1;
    wait_cs_low(2 * SP, c);
    n_cmp++;
    if (c - n !== SP) begin n_fail++; $display("FAIL t1_cs_latency: got %0d want %0d", c - n, SP); end
    wait_strobe(FL + 10, s);
    n_cmp++;
    if (s !== c + FL) begin n_fail++; $display("FAIL t1_strobe_time: got %0d want %0d", s - c, FL); end
    n_cmp++;
    if (origin_data !== 12'hABC) begin n_fail++; $display("FAIL t1_data: got %h want abc", origin_data); end
    n_cmp++;
    if (sclk_rises !== 16) begin n_fail++; $display("FAIL t1_sclk_pulses: got %0d want 16", sclk_rises); end
    n_cmp++;
    if (din_bits !== {2'b00, CH, 11'b0}) begin
      n_fail++; $display("FAIL t1_din_frame: got %b want %b", din_bits, {2'b00, CH, 11'b0});
    end
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL t1_busy_done: got %b want 1", busy); end
    last_s = s;
    @(negedge clk);
    n_cmp++;
    if ({busy, en_kalman} !== 2'b00) begin n_fail++; $display("FAIL t1_after_done: got %b want 00", {busy, en_kalman}); end
  endtask

  task automatic test_extremes();
    int s;
    logic [11:0] vals [2] = '{12'h000, 12'hFFF};
    for (int k = 0; k < 2; k++) begin
      adc_val = vals[k];
      wait_strobe(SP + 10, s);
      n_cmp++;
      if (s - last_s !== SP) begin n_fail++; $display("FAIL t2_interval%0d: got %0d want %0d", k, s - last_s, SP); end
      n_cmp++;
      if (origin_data !== vals[k]) begin n_fail++; $display("FAIL t2_data%0d: got %h want %h", k, origin_data, vals[k]); end
      last_s = s;
    end
    n_cmp++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL t2_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_random_frames();
    int s;
    logic [11:0] v;
    for (int k = 0; k < 5; k++) begin
      v = 12'($urandom_range(0, 4095));
      adc_val = v;
      wait_strobe(SP + 10, s);
      n_cmp++;
      if (s - last_s !== SP || origin_data !== v) begin
        n_fail++; $display("FAIL rand_frame%0d: got %h after %0d want %h after %0d", k, origin_data, s - last_s, v, SP);
      end
      n_cmp++;
      if (din_bits !== {2'b00, CH, 11'b0}) begin n_fail++; $display("FAIL rand_din%0d: got %b", k, din_bits); end
      last_s = s;
    end
  endtask

  task automatic test_en_drop();
    int c, s, n;
    logic [11:0] v, v2;
    logic quiet;
    v = 12'($urandom_range(0, 4095));
    adc_val = v;
    wait_cs_low(SP, c);
    repeat (CD + 2 * CD * 7) @(negedge clk);
    en = 1'b0;
    wait_strobe(FL + 10, s);
    n_cmp++;
    if (s !== c + FL || origin_data !== v) begin
      n_fail++; $display("FAIL t4_finish: got %h at +%0d want %h at +%0d", origin_data, s - c, v, FL);
    end
    quiet = 1'b1;
    for (int i = 0; i < 3 * SP; i++) begin
      @(negedge clk);
      if (adc_cs_n !== 1'b1 || en_kalman !== 1'b0) quiet = 1'b0;
    end
    n_cmp++;
    if (quiet !== 1'b1 || origin_data !== v) begin
      n_fail++; $display("FAIL t4_idle_hold: quiet %b data %h want 1 %h", quiet, origin_data, v);
    end
    v2 = 12'($urandom_range(0, 4095));
    adc_val = v2;
    n = cyc; en = 1'b1;
    wait_cs_low(2 * SP, c);
    n_cmp++;
    if (c - n !== SP) begin n_fail++; $display("FAIL t4_restart: got %0d want %0d", c - n, SP); end
    wait_strobe(FL + 10, s);
    n_cmp++;
    if (origin_data !== v2) begin n_fail++; $display("FAIL t4_restart_data: got %h want %h", origin_data, v2); end
  endtask

  task automatic test_reset_mid_frame();
    int c, c2, r, sc, s;
    logic [11:0] v;
    v = 12'($urandom_range(1, 4095));
    adc_val = v;
    wait_cs_low(SP, c);
    repeat (CD + 2 * CD * 10) @(negedge clk);
    sc = strobe_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({adc_cs_n, adc_sclk, busy, en_kalman, overrun} !== 5'b11000 || origin_data !== 12'h000) begin
      n_fail++; $display("FAIL t5_reset_vals: got %b data %h want 11000 data 000",
                         {adc_cs_n, adc_sclk, busy, en_kalman, overrun}, origin_data);
    end
    rst_n = 1'b1;
    r = cyc;
    wait_cs_low(2 * SP, c2);
    n_cmp++;
    if (c2 - r !== SP) begin n_fail++; $display("FAIL t5_restart: got %0d want %0d", c2 - r, SP); end
    n_cmp++;
    if (strobe_cnt !== sc) begin n_fail++; $display("FAIL t5_no_strobe: got %0d strobes want 0", strobe_cnt - sc); end
    wait_strobe(FL + 10, s);
    n_cmp++;
    if (s !== c2 + FL || origin_data !== v) begin
      n_fail++; $display("FAIL t5_next_frame: got %h at +%0d want %h at +%0d", origin_data, s - c2, v, FL);
    end
    en = 1'b0;
  endtask

  task automatic test_overrun();
    int n, t, s_last, ovr_exp, ovr_at, win;
    int exp_q[$], got_q[$];
    logic [11:0] v;
    v = 12'($urandom_range(0, 4095));
    adc_val2 = v;
    win = 320; ovr_at = -1; ovr_exp = -1; s_last = -1000;
    n = cyc; en2 = 1'b1;
    for (int i = 0; i < win; i++) begin
      @(negedge clk);
      if (en_kalman2 === 1'b1) begin
        got_q.push_back(cyc - n);
        n_cmp++;
        if (origin_data2 !== v) begin n_fail++; $display("FAIL t3_data: got %h want %h", origin_data2, v); end
      end
      if (overrun2 === 1'b1 && ovr_at < 0) ovr_at = cyc - n;
    end
    en2 = 1'b0;
    // Ticks fall every SP2 cycles; one is accepted only once the previous frame's DONE cycle has passed.
    for (int k = 1; k * SP2 <= win; k++) begin
      t = k * SP2;
      if (t >= s_last + 2) begin
        s_last = t + FL;
        if (s_last <= win) exp_q.push_back(s_last);
      end else if (ovr_exp < 0) begin
        ovr_exp = t;
      end
    end
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL t3_strobe_count: got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        n_cmp++;
        if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL t3_strobe_time%0d: got %0d want %0d", k, got_q[k], exp_q[k]); end
      end
    end
    n_cmp++;
    if (ovr_at !== ovr_exp) begin n_fail++; $display("FAIL t3_overrun_time: got %0d want %0d", ovr_at, ovr_exp); end
  endtask

  task automatic test_avg4();
    int n, c, s, sc, sum;
    logic [11:0] vals [4];
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    vals = '{12'd100, 12'd101, 12'd102, 12'd104};
    adc_val = vals[0];
    n = cyc; en = 1'b1;
    for (int g = 0; g < 2; g++) begin
      sc = strobe_cnt;
      sum = 0;
      for (int k = 0; k < 4; k++) sum += int'(vals[k]);
      for (int k = 0; k < 4; k++) begin
        wait_cs_low(2 * SP, c);
        n_cmp++;
        if (c - n !== (4 * g + k + 1) * SP) begin
          n_fail++; $display("FAIL avg_frame_start%0d_%0d: got %0d want %0d", g, k, c - n, (4 * g + k + 1) * SP);
        end
        if (k < 3) begin
          adc_val = vals[k + 1];
          repeat (FL + 2) @(negedge clk);
        end
      end
      n_cmp++;
      if (strobe_cnt !== sc) begin n_fail++; $display("FAIL avg_early_strobe%0d: got %0d want 0", g, strobe_cnt - sc); end
      for (int k = 0; k < 4; k++) vals[k] = 12'($urandom_range(0, 4095));
      adc_val = vals[0];
      wait_strobe(FL + 10, s);
      n_cmp++;
      if (s - n !== (4 * g + 4) * SP + FL || origin_data !== 12'(sum / 4)) begin
        n_fail++; $display("FAIL avg_result%0d: got %0d at %0d want %0d at %0d", g, origin_data, s - n,
                           sum / 4, (4 * g + 4) * SP + FL);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_strobe_spacing();
    n_cmp++;
    if (consec_seen !== 1'b0) begin n_fail++; $display("FAIL strobe_back_to_back: got %b want 0", consec_seen); end
  endtask

  initial begin
    test_reset();
`ifdef SAMPLE_AVG4_EN
    test_avg4();
`else
    test_single_frame();
    test_extremes();
    test_random_frames();
    test_en_drop();
    test_reset_mid_frame();
    test_overrun();
`endif
    test_strobe_spacing();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
